// File: rtl/vga_frame_sequencer_if.sv
// Config-update handshake between game logic (master) and the scan sequencer (slave).
// A 4-phase req/ack exchange, plus visibility of the pending flag and the committed config.
interface vga_frame_sequencer_if #(
  parameter int DATA_W = 20
) ();
  logic              upd_req;
  logic [DATA_W-1:0] upd_data;
  logic              upd_ack;
  logic              upd_pending;
  logic [DATA_W-1:0] cfg_data;

  modport master (
    output upd_req,
    output upd_data,
    input  upd_ack,
    input  upd_pending,
    input  cfg_data
  );

  modport slave (
    input  upd_req,
    input  upd_data,
    output upd_ack,
    output upd_pending,
    output cfg_data
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// VGA scan sequencer: pixel-rate divider, pixel/line counters, frame and vblank strobes,
// and a config shadow register that commits only at the start of vertical blank.
module vga_frame_sequencer #(
  parameter int                CLK_DIV     = 2,
  parameter int                H_TOTAL     = 800,
  parameter int                V_TOTAL     = 525,
  parameter int                H_ACT_START = 144,
  parameter int                H_ACT_END   = 784,
  parameter int                V_ACT_START = 35,
  parameter int                V_ACT_END   = 515,
  parameter int                DATA_W      = 20,
  parameter logic [DATA_W-1:0] CFG_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  pix_en,
  output logic [9:0]            current_pixel,
  output logic [9:0]            current_line,
  output logic                  active,
  output logic                  vblank,
  output logic                  frame_start,
  output logic                  vblank_start,
  output logic [15:0]           frame_count,
  vga_frame_sequencer_if.slave  upd
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      VBL_PREV = 10'(V_ACT_END - 1);
  localparam logic [9:0]      H_AS     = 10'(H_ACT_START);
  localparam logic [9:0]      H_AE     = 10'(H_ACT_END);
  localparam logic [9:0]      V_AS     = 10'(V_ACT_START);
  localparam logic [9:0]      V_AE     = 10'(V_ACT_END);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK
  } upd_state_t;

  logic [DIV_W-1:0]  div_cnt;
  logic              line_wrap;
  upd_state_t        state;
  logic [DATA_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      pix_en  <= 1'b0;
    end
  end

  assign line_wrap = pix_en && (current_pixel == H_LAST);

  // Strobes are computed from the pre-update counters so they line up with the new position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_pixel <= '0;
      current_line  <= '0;
      frame_start   <= 1'b0;
      vblank_start  <= 1'b0;
      frame_count   <= '0;
    end else begin
      frame_start  <= line_wrap && (current_line == V_LAST);
      vblank_start <= line_wrap && (current_line == VBL_PREV);
      if (pix_en) begin
        if (current_pixel == H_LAST) begin
          current_pixel <= '0;
          if (current_line == V_LAST) begin
            current_line <= '0;
            frame_count  <= frame_count + 16'd1;
          end else begin
            current_line <= current_line + 10'd1;
          end
        end else begin
          current_pixel <= current_pixel + 10'd1;
        end
      end
    end
  end

  assign vblank = (current_line < V_AS) || (current_line >= V_AE);
  assign active = !vblank && (current_pixel >= H_AS) && (current_pixel < H_AE);

  // A capture coinciding with vblank_start lands in PEND one clock late, so it waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shadow          <= '0;
      upd.cfg_data    <= CFG_RESET;
      upd.upd_ack     <= 1'b0;
      upd.upd_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (upd.upd_req) begin
            shadow          <= upd.upd_data;
            upd.upd_pending <= 1'b1;
            state           <= PEND;
          end
        end
        PEND: begin
          if (vblank_start) begin
            upd.cfg_data    <= shadow;
            upd.upd_pending <= 1'b0;
            upd.upd_ack     <= 1'b1;
            state           <= ACK;
          end
        end
        ACK: begin
          if (!upd.upd_req) begin
            upd.upd_ack <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state           <= IDLE;
          upd.upd_ack     <= 1'b0;
          upd.upd_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer: two shrunken-timing instances (CLK_DIV 3 and 1) checked
// every clock against an arithmetic scan model and a request/commit model of the update path.
module tb_vga_frame_sequencer;

  localparam int H      = 20;
  localparam int V      = 12;
  localparam int HAS    = 4;
  localparam int HAE    = 16;
  localparam int VAS    = 2;
  localparam int VAE    = 10;
  localparam int FRAME  = H * V;
  localparam int DIV_A  = 3;
  localparam int DIV_B  = 1;
  localparam logic [19:0] CFG_A = 20'h5A5A5;
  localparam logic [19:0] CFG_B = 20'h00000;

  typedef struct {
    logic [19:0] shadow;
    logic [19:0] cfg;
    bit          ack;
    bit          pend;
  } upd_model_t;

  logic        clk;
  logic        rst_n;
  logic        pix_en_a, pix_en_b;
  logic [9:0]  px_a, ln_a, px_b, ln_b;
  logic        act_a, act_b, vb_a, vb_b;
  logic        fs_a, fs_b, vbs_a, vbs_b;
  logic [15:0] fc_a, fc_b;

  int          checks;
  int          errors;
  int          t;
  bit          model_ok;
  upd_model_t  ma, mb;

  vga_frame_sequencer_if #(.DATA_W(20)) if_a ();
  vga_frame_sequencer_if #(.DATA_W(20)) if_b ();

  vga_frame_sequencer #(
    .CLK_DIV(DIV_A), .H_TOTAL(H), .V_TOTAL(V), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE), .DATA_W(20), .CFG_RESET(CFG_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en_a), .current_pixel(px_a), .current_line(ln_a),
    .active(act_a), .vblank(vb_a), .frame_start(fs_a), .vblank_start(vbs_a),
    .frame_count(fc_a), .upd(if_a)
  );

  vga_frame_sequencer #(
    .CLK_DIV(DIV_B), .H_TOTAL(H), .V_TOTAL(V), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE), .DATA_W(20), .CFG_RESET(CFG_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en_b), .current_pixel(px_b), .current_line(ln_b),
    .active(act_b), .vblank(vb_b), .frame_start(fs_b), .vblank_start(vbs_b),
    .frame_count(fc_b), .upd(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel steps taken after t clock edges since reset release.
  function automatic int incs(input int tt, input int d);
    return (tt < 1) ? 0 : (tt - 1) / d;
  endfunction

  function automatic bit stepped(input int tt, input int d);
    return (tt >= d + 1) && ((tt - 1) % d == 0);
  endfunction

  function automatic bit expVbs(input int tt, input int d);
    return stepped(tt, d) && (incs(tt, d) % FRAME == VAE * H);
  endfunction

  function automatic upd_model_t updStep(input upd_model_t m, input logic req,
                                         input logic [19:0] data, input bit vbs);
    upd_model_t n;
    n = m;
    if (m.pend) begin
      if (vbs) begin
        n.cfg  = m.shadow;
        n.pend = 1'b0;
        n.ack  = 1'b1;
      end
    end else if (m.ack) begin
      if (!req) n.ack = 1'b0;
    end else if (req) begin
      n.shadow = data;
      n.pend   = 1'b1;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", name, t, actual, expected);
    end
  endtask

  task automatic checkScan(input string tag, input int tt, input int d, input logic pe,
                           input logic [9:0] px, input logic [9:0] ln, input logic act,
                           input logic vb, input logic fs, input logic vbs,
                           input logic [15:0] fc, input upd_model_t m, input logic ack,
                           input logic pend, input logic [19:0] cfg);
    int n, p, epx, eln;
    n   = incs(tt, d);
    p   = n % FRAME;
    epx = p % H;
    eln = p / H;
    checkOutput({tag, ".pix_en"}, 32'(pe), 32'(tt >= 1 && tt % d == 0));
    checkOutput({tag, ".pixel"}, 32'(px), 32'(epx));
    checkOutput({tag, ".line"}, 32'(ln), 32'(eln));
    checkOutput({tag, ".active"}, 32'(act),
                32'(eln >= VAS && eln < VAE && epx >= HAS && epx < HAE));
    checkOutput({tag, ".vblank"}, 32'(vb), 32'(eln < VAS || eln >= VAE));
    checkOutput({tag, ".frame_start"}, 32'(fs), 32'(stepped(tt, d) && p == 0));
    checkOutput({tag, ".vblank_start"}, 32'(vbs), 32'(expVbs(tt, d)));
    checkOutput({tag, ".frame_count"}, 32'(fc), 32'((n / FRAME) % 65536));
    checkOutput({tag, ".upd_ack"}, 32'(ack), 32'(m.ack));
    checkOutput({tag, ".upd_pending"}, 32'(pend), 32'(m.pend));
    checkOutput({tag, ".cfg_data"}, 32'(cfg), 32'(m.cfg));
  endtask

  task automatic applyStimulus(input logic req_a, input logic [19:0] data_a,
                               input logic req_b, input logic [19:0] data_b);
    if_a.upd_req  = req_a;
    if_a.upd_data = data_a;
    if_b.upd_req  = req_b;
    if_b.upd_data = data_b;
  endtask

  // Model advances on each edge using the inputs and the strobe seen before the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      t        = 0;
      ma       = '{shadow: '0, cfg: CFG_A, ack: 1'b0, pend: 1'b0};
      mb       = '{shadow: '0, cfg: CFG_B, ack: 1'b0, pend: 1'b0};
      model_ok = 1'b1;
    end else begin
      ma = updStep(ma, if_a.upd_req, if_a.upd_data, expVbs(t, DIV_A));
      mb = updStep(mb, if_b.upd_req, if_b.upd_data, expVbs(t, DIV_B));
      t  = t + 1;
    end
    #1;
    if (model_ok) begin
      checkScan("A", t, DIV_A, pix_en_a, px_a, ln_a, act_a, vb_a, fs_a, vbs_a, fc_a, ma,
                if_a.upd_ack, if_a.upd_pending, if_a.cfg_data);
      checkScan("B", t, DIV_B, pix_en_b, px_b, ln_b, act_b, vb_b, fs_b, vbs_b, fc_b, mb,
                if_b.upd_ack, if_b.upd_pending, if_b.cfg_data);
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    t        = 0;
    model_ok = 1'b0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 20'h0, 1'b0, 20'h0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst.pixel_a", 32'(px_a), 32'd0);
    checkOutput("rst.cfg_a", 32'(if_a.cfg_data), 32'h5A5A5);
    checkOutput("rst.fc_b", 32'(fc_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed pass: literal expectations for divider start, strobes and one full update.
    for (int e = 1; e <= 730; e++) begin
      @(posedge clk);
      #2;
      case (e)
        1: checkOutput("B.first_pix_en", 32'(pix_en_b), 32'd1);
        2: begin
          checkOutput("A.no_early_pix_en", 32'(pix_en_a), 32'd0);
          checkOutput("B.first_step", 32'(px_b), 32'd1);
        end
        3: begin
          checkOutput("A.first_pix_en", 32'(pix_en_a), 32'd1);
          checkOutput("A.pixel_before_step", 32'(px_a), 32'd0);
        end
        4: begin
          checkOutput("A.first_step", 32'(px_a), 32'd1);
          checkOutput("A.line_zero", 32'(ln_a), 32'd0);
        end
        50: begin
          checkOutput("A.captured", 32'(if_a.upd_pending), 32'd1);
          checkOutput("A.cfg_not_yet", 32'(if_a.cfg_data), 32'h5A5A5);
        end
        133: checkOutput("A.active_start", 32'(act_a), 32'd1);
        169: checkOutput("A.active_end", 32'(act_a), 32'd0);
        202: begin
          checkOutput("B.commit_cfg", 32'(if_b.cfg_data), 32'hABCDE);
          checkOutput("B.commit_ack", 32'(if_b.upd_ack), 32'd1);
        end
        241: begin
          checkOutput("B.frame_start1", 32'(fs_b), 32'd1);
          checkOutput("B.frame_count1", 32'(fc_b), 32'd1);
        end
        242: checkOutput("B.frame_start_pulse", 32'(fs_b), 32'd0);
        600: checkOutput("A.pending_hold", 32'(if_a.upd_pending), 32'd1);
        601: begin
          checkOutput("A.vblank_start", 32'(vbs_a), 32'd1);
          checkOutput("A.cfg_before_commit", 32'(if_a.cfg_data), 32'h5A5A5);
        end
        602: begin
          checkOutput("A.commit_cfg", 32'(if_a.cfg_data), 32'hABCDE);
          checkOutput("A.commit_ack", 32'(if_a.upd_ack), 32'd1);
          checkOutput("A.commit_pending", 32'(if_a.upd_pending), 32'd0);
        end
        613: begin
          checkOutput("A.active_in_vblank", 32'(act_a), 32'd0);
          checkOutput("A.vblank_line", 32'(vb_a), 32'd1);
        end
        700: begin
          checkOutput("A.ack_held", 32'(if_a.upd_ack), 32'd1);
          checkOutput("A.no_recapture", 32'(if_a.cfg_data), 32'hABCDE);
        end
        701: begin
          checkOutput("A.ack_drop", 32'(if_a.upd_ack), 32'd0);
          checkOutput("B.ack_drop", 32'(if_b.upd_ack), 32'd0);
          checkOutput("B.cfg_kept", 32'(if_b.cfg_data), 32'hABCDE);
        end
        721: begin
          checkOutput("A.frame_start1", 32'(fs_a), 32'd1);
          checkOutput("A.frame_count1", 32'(fc_a), 32'd1);
          checkOutput("B.frame_count3", 32'(fc_b), 32'd3);
        end
        default: ;
      endcase
      @(negedge clk);
      if (e == 49)  applyStimulus(1'b1, 20'hABCDE, 1'b1, 20'hABCDE);
      if (e == 609) applyStimulus(1'b1, 20'h12345, 1'b1, 20'h12345);
      if (e == 700) applyStimulus(1'b0, 20'h12345, 1'b0, 20'h12345);
    end

    // Reset while a payload is pending must discard it.
    applyStimulus(1'b1, 20'h13579, 1'b1, 20'h13579);
    @(posedge clk);
    #2;
    checkOutput("A.pending_pre_reset", 32'(if_a.upd_pending), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst2.cfg_a", 32'(if_a.cfg_data), 32'h5A5A5);
    checkOutput("rst2.cfg_b", 32'(if_b.cfg_data), 32'h00000);
    checkOutput("rst2.pending_a", 32'(if_a.upd_pending), 32'd0);
    checkOutput("rst2.ack_b", 32'(if_b.upd_ack), 32'd0);
    applyStimulus(1'b0, 20'h0, 1'b0, 20'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(posedge clk);
    #2;
    checkOutput("A.no_commit_after_reset", 32'(if_a.cfg_data), 32'h5A5A5);
    checkOutput("B.no_commit_after_reset", 32'(if_b.cfg_data), 32'h00000);

    // Random pass: bursty 4-phase requests with data changing every clock.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (i == 9000) rst_n = 1'b0;
      if (i == 9003) rst_n = 1'b1;
      applyStimulus(
        if_a.upd_req ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 4),
        20'($urandom),
        if_b.upd_req ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 6),
        20'($urandom));
    end
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
